// File: rtl/ram_512x8.sv
// ----------------------------------------------------------------------------
// ram_512x8
// 512-byte, byte-addressed, big-endian data/instruction RAM for the basic
// RISC CPU. Byte, halfword and word accesses are supported. Each access takes
// one clock cycle. Completion is signalled by mfc (memory function complete).
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset (outputs only)
//   enable       in   1        access request
//   read_write   in   1        1 = read, 0 = write
//   data_length  in   2        00 byte, 01 halfword, 10 word, 11 reserved
//   address      in   ADDR_W   byte address of the most-significant byte
//   data_in      in   DATA_W   write data, right-justified
//   data_out     out  DATA_W   read data, right-justified, zero-extended
//   mfc          out  1        memory function complete
//
// Configuration macro
//   RAM_ALIGN_CHECK_EN : when defined, misaligned halfword/word accesses are
//                        suppressed (no write, read returns 0, mfc still
//                        handshakes). When undefined, any address is allowed
//                        and multi-byte accesses wrap modulo the depth.
// ----------------------------------------------------------------------------
module ram_512x8 #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              read_write,
    input  logic [1:0]        data_length,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mfc
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage; not reset so contents survive rst_n and can be preloaded.
    logic [7:0] memory [0:DEPTH-1];

    logic [ADDR_W-1:0] addr0_s;
    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [ADDR_W-1:0] addr3_s;
    logic              access_s;
    logic              misaligned_s;
    logic [3:0]        wr_en_s;
    logic [7:0]        wr_byte0_s;
    logic [7:0]        wr_byte1_s;
    logic [7:0]        wr_byte2_s;
    logic [7:0]        wr_byte3_s;
    logic [DATA_W-1:0] rd_data_s;

    // Byte-lane addresses; the natural ADDR_W-bit overflow gives the wrap.
    always_comb begin
        addr0_s = address;
        addr1_s = address + ADDR_W'(1);
        addr2_s = address + ADDR_W'(2);
        addr3_s = address + ADDR_W'(3);
    end

    // A new access starts only on the first enabled edge of a pulse.
    always_comb begin
        access_s = enable & ~mfc;
    end

    // Alignment qualifier for multi-byte accesses.
    always_comb begin
`ifdef RAM_ALIGN_CHECK_EN
        case (data_length)
            2'b01:   misaligned_s = address[0];
            2'b10:   misaligned_s = (address[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
`else
        misaligned_s = 1'b0;
`endif
    end

    // Big-endian lane steering: lane 0 is always the byte at the base address
    // and holds the most-significant byte of the selected width.
    always_comb begin
        rd_data_s  = {DATA_W{1'b0}};
        wr_en_s    = 4'b0000;
        wr_byte0_s = 8'h00;
        wr_byte1_s = 8'h00;
        wr_byte2_s = 8'h00;
        wr_byte3_s = 8'h00;
        case (data_length)
            2'b00: begin
                rd_data_s  = {24'h00_0000, memory[addr0_s]};
                wr_en_s    = 4'b0001;
                wr_byte0_s = data_in[7:0];
            end
            2'b01: begin
                rd_data_s  = {16'h0000, memory[addr0_s], memory[addr1_s]};
                wr_en_s    = 4'b0011;
                wr_byte0_s = data_in[15:8];
                wr_byte1_s = data_in[7:0];
            end
            2'b10: begin
                rd_data_s  = {memory[addr0_s], memory[addr1_s],
                              memory[addr2_s], memory[addr3_s]};
                wr_en_s    = 4'b1111;
                wr_byte0_s = data_in[31:24];
                wr_byte1_s = data_in[23:16];
                wr_byte2_s = data_in[15:8];
                wr_byte3_s = data_in[7:0];
            end
            default: begin
                // Reserved length: no bytes selected, read returns zero.
                rd_data_s = {DATA_W{1'b0}};
                wr_en_s   = 4'b0000;
            end
        endcase
        if (misaligned_s) begin
            rd_data_s = {DATA_W{1'b0}};
            wr_en_s   = 4'b0000;
        end else begin
            wr_en_s   = wr_en_s;
        end
    end

    // Memory array write port; committed bytes persist across rst_n.
    always_ff @(posedge clk) begin
        if (access_s && !read_write) begin
            if (wr_en_s[0]) memory[addr0_s] <= wr_byte0_s;
            if (wr_en_s[1]) memory[addr1_s] <= wr_byte1_s;
            if (wr_en_s[2]) memory[addr2_s] <= wr_byte2_s;
            if (wr_en_s[3]) memory[addr3_s] <= wr_byte3_s;
        end
    end

    // Handshake and read-data register; data_out changes only on reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= {DATA_W{1'b0}};
            mfc      <= 1'b0;
        end else if (!enable) begin
            mfc      <= 1'b0;
        end else if (!mfc) begin
            mfc      <= 1'b1;
            if (read_write) begin
                data_out <= rd_data_s;
            end
        end
    end

endmodule

// File: tb/tb_ram_512x8.sv
// ----------------------------------------------------------------------------
// tb_ram_512x8
// Self-checking bench for ram_512x8: directed scenarios plus randomized
// accesses compared against a byte-array reference model. Honors the
// RAM_ALIGN_CHECK_EN macro in the same way as the design.
// ----------------------------------------------------------------------------
module tb_ram_512x8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        read_write;
    logic [1:0]  data_length;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc;

    int n_checks;
    int n_fails;

    logic [7:0]  ref_mem [0:511];
    logic [31:0] ref_dout;

    ram_512x8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .read_write  (read_write),
        .data_length (data_length),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .mfc         (mfc)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: one access, computed as n consecutive wrapped bytes.
    task automatic model_access(input logic rw, input logic [1:0] len,
                                input int a, input logic [31:0] din);
        int  n;
        bit  skip;
        logic [31:0] v;
        n    = (len == 2'b11) ? 0 : (1 << len);
        skip = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
        if (n > 1 && (a % n) != 0) skip = 1'b1;
`endif
        if (skip) n = 0;
        if (rw) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[(a + k) % 512]);
            ref_dout = v;
        end else begin
            for (int k = 0; k < n; k++)
                ref_mem[(a + k) % 512] = 8'((din >> (8 * (n - 1 - k))) & 32'hFF);
        end
    endtask

    function automatic int mem_diffs();
        int d;
        d = 0;
        for (int i = 0; i < 512; i++)
            if (dut.memory[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // One enable pulse held for 'hold' cycles; inputs are scrambled after the
    // first edge to show no second access is taken.
    task automatic access(input logic rw, input logic [1:0] len,
                          input logic [8:0] a, input logic [31:0] din,
                          input int hold);
        @(negedge clk);
        enable = 1'b1; read_write = rw; data_length = len;
        address = a; data_in = din;
        @(posedge clk); #1;
        model_access(rw, len, int'(a), din);
        check_eq("mfc_set", 32'(mfc), 32'd1);
        check_eq("dout_acc", data_out, ref_dout);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            data_in = ~din; address = a + 9'd5; read_write = ~rw;
            @(posedge clk); #1;
            check_eq("mfc_hold", 32'(mfc), 32'd1);
            check_eq("dout_hold", data_out, ref_dout);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check_eq("mfc_clr", 32'(mfc), 32'd0);
        check_eq("dout_keep", data_out, ref_dout);
    endtask

    initial begin
        logic [31:0] r;
        n_checks = 0; n_fails = 0;
        rst_n = 1'b0; enable = 1'b0; read_write = 1'b1;
        data_length = 2'b00; address = 9'd0; data_in = 32'h0;
        ref_dout = 32'h0;
        for (int i = 0; i < 512; i++) begin
            r = $urandom;
            ref_mem[i] = (i < 16) ? 8'(i) : r[7:0];
            dut.memory[i] = ref_mem[i];
        end
        #12;
        check_eq("rst_dout", data_out, 32'h0);
        check_eq("rst_mfc", 32'(mfc), 32'd0);
        rst_n = 1'b1;

        // Preloaded byte reads
        for (int a = 0; a < 16; a++) begin
            access(1'b1, 2'b00, 9'(a), 32'h0, 1);
            check_eq("byte_rd_preload", data_out, 32'(a));
        end

        // Byte write / read
        access(1'b0, 2'b00, 9'd0, 32'hFFFF_FF0A, 1);
        access(1'b1, 2'b00, 9'd0, 32'h0, 1);
        check_eq("byte_wr_rd", data_out, 32'h0000_000A);
        check_eq("byte_mem1", 32'(dut.memory[1]), 32'h01);

        // Halfword write / read
        access(1'b0, 2'b01, 9'd2, 32'h1234_0400, 1);
        access(1'b1, 2'b01, 9'd2, 32'h0, 1);
        check_eq("half_wr_rd", data_out, 32'h0000_0400);
        check_eq("half_mem2", 32'(dut.memory[2]), 32'h04);
        check_eq("half_mem3", 32'(dut.memory[3]), 32'h00);

        // Word write / read
        access(1'b0, 2'b10, 9'd8, 32'h0010_0000, 1);
        access(1'b1, 2'b10, 9'd8, 32'h0, 1);
        check_eq("word_wr_rd", data_out, 32'h0010_0000);
        check_eq("word_mem9", 32'(dut.memory[9]), 32'h10);
        check_eq("word_mem11", 32'(dut.memory[11]), 32'h00);

        // Wrapping word write at 510
        access(1'b0, 2'b10, 9'd510, 32'hAABB_CCDD, 1);
`ifdef RAM_ALIGN_CHECK_EN
        check_eq("wrap_mem0", 32'(dut.memory[0]), 32'h0A);
        check_eq("wrap_mem1", 32'(dut.memory[1]), 32'h01);
`else
        check_eq("wrap_mem510", 32'(dut.memory[510]), 32'hAA);
        check_eq("wrap_mem511", 32'(dut.memory[511]), 32'hBB);
        check_eq("wrap_mem0", 32'(dut.memory[0]), 32'hCC);
        check_eq("wrap_mem1", 32'(dut.memory[1]), 32'hDD);
`endif
        access(1'b1, 2'b10, 9'd510, 32'h0, 1);
        check_eq("wrap_mem_all", 32'(mem_diffs()), 32'd0);

        // Reserved length
        access(1'b1, 2'b11, 9'd4, 32'h0, 1);
        check_eq("rsv_rd", data_out, 32'h0);
        access(1'b0, 2'b11, 9'd4, 32'hDEAD_BEEF, 1);
        check_eq("rsv_wr_mem", 32'(mem_diffs()), 32'd0);

        // Enable held 3 cycles: exactly one access
        access(1'b0, 2'b10, 9'd20, 32'h5566_7788, 3);
        check_eq("hold_mem", 32'(mem_diffs()), 32'd0);
        access(1'b1, 2'b10, 9'd20, 32'h0, 3);
        check_eq("hold_rd", data_out, 32'h5566_7788);

        // Randomized accesses, biased toward the wrap boundary
        for (int t = 0; t < 300; t++) begin
            logic [8:0] a;
            r = $urandom;
            a = r[0] ? 9'($urandom_range(505, 511)) : 9'($urandom_range(0, 511));
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                   $urandom, $urandom_range(1, 3));
        end
        check_eq("rand_mem", 32'(mem_diffs()), 32'd0);

        // Reset mid-pulse: outputs clear asynchronously, memory intact
        @(negedge clk);
        enable = 1'b1; read_write = 1'b1; data_length = 2'b10; address = 9'd20;
        @(posedge clk); #2;
        check_eq("pre_rst_mfc", 32'(mfc), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dout", data_out, 32'h0);
        check_eq("async_rst_mfc", 32'(mfc), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_mem_intact", 32'(mem_diffs()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
